// File: rtl/ob_pkg.sv
// Shared order-book package.
//  - Opcodes for market-data and dump responses.
//  - Bit positions of the fields in a 32-bit order word:
//    {price[31:16], is_buy[15], is_bot[14], qty[13:0]}.
//  - State encoding for the dump TX framer.
package ob_pkg;

  localparam logic [23:0] OP_MARKET = 24'h102030;
  localparam logic [23:0] OP_DUMP   = 24'hF0E0D0;

  localparam int unsigned PRICE_MSB  = 31;
  localparam int unsigned PRICE_LSB  = 16;
  localparam int unsigned IS_BUY_BIT = 15;
  localparam int unsigned IS_BOT_BIT = 14;
  localparam int unsigned QTY_MSB    = 13;
  localparam int unsigned QTY_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_WORD,
    ST_DATA,
    ST_CSUM
  } dump_tx_state_t;

  // Build an order word from its fields.
  function automatic logic [31:0] ob_order_word(
    input logic [15:0] price,
    input logic        is_buy,
    input logic        is_bot,
    input logic [13:0] qty
  );
    return {price, is_buy, is_bot, qty};
  endfunction

endpackage

// File: rtl/ob_dump_tx_framer.sv
// Transmit-side framer for order-book dump responses (clk_udp domain).
// Serialises start_count 32-bit order words into one byte frame:
//   OPCODE[23:16], OPCODE[15:8], OPCODE[7:0], count[7:0],
//   4 bytes per word (MSB first), XOR checksum (tlast).
// Ports:
//   clk_udp, rst_udp             clock, synchronous active-high reset
//   start_valid/count/ready      dump request (accepted only in IDLE)
//   in_tdata/tvalid/tlast/tready order-word stream (accepted only in WAIT_WORD)
//   tx_fifo_tdata/tvalid/tlast/tready  byte stream to the UDP TX FIFO
//   busy                         high whenever not IDLE
//   len_err                      one-cycle pulse when in_tlast disagrees with count
module ob_dump_tx_framer
  import ob_pkg::*;
#(
  parameter logic [23:0] OPCODE = OP_DUMP,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk_udp,
  input  logic             rst_udp,
  input  logic             start_valid,
  input  logic [CNT_W-1:0] start_count,
  output logic             start_ready,
  input  logic [31:0]      in_tdata,
  input  logic             in_tvalid,
  input  logic             in_tlast,
  output logic             in_tready,
  output logic [7:0]       tx_fifo_tdata,
  output logic             tx_fifo_tvalid,
  output logic             tx_fifo_tlast,
  input  logic             tx_fifo_tready,
  output logic             busy,
  output logic             len_err
);

  dump_tx_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_idx;
  logic [31:0]      r_shift;
  logic [7:0]       r_csum;
  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_in_tready;
  logic             r_start_ready;
  logic             r_busy;
  logic             r_len_err;

  logic             w_xfer;
  logic [7:0]       w_csum_nxt;
  logic [7:0]       w_cnt_byte;
  logic             w_last_word;

  assign w_xfer      = r_tvalid && tx_fifo_tready;
  // Checksum including the byte currently on the bus; used when that byte
  // transfers and the next byte presented is the checksum itself.
  assign w_csum_nxt  = r_csum ^ r_tdata;
  assign w_cnt_byte  = 8'(r_cnt);
  assign w_last_word = (r_rem == CNT_W'(1));

  always_ff @(posedge clk_udp) begin
    if (rst_udp) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_csum        <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_in_tready   <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_len_err     <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_cnt         <= start_count;
            r_rem         <= start_count;
            r_csum        <= '0;
            r_idx         <= '0;
            r_tdata       <= OPCODE[23:16];
            r_tvalid      <= 1'b1;
            r_tlast       <= 1'b0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (w_xfer) begin
            r_csum <= w_csum_nxt;
            r_idx  <= r_idx + 2'd1;
            unique case (r_idx)
              2'd0:    r_tdata <= OPCODE[15:8];
              2'd1:    r_tdata <= OPCODE[7:0];
              2'd2:    r_tdata <= w_cnt_byte;
              default: begin
                if (r_cnt == '0) begin
                  r_tdata <= w_csum_nxt;
                  r_tlast <= 1'b1;
                  r_state <= ST_CSUM;
                end else begin
                  r_tvalid    <= 1'b0;
                  r_in_tready <= 1'b1;
                  r_state     <= ST_WAIT_WORD;
                end
              end
            endcase
          end
        end

        ST_WAIT_WORD: begin
          if (in_tvalid) begin
            // First byte goes straight to the bus; the rest queue in r_shift.
            r_tdata     <= in_tdata[31:24];
            r_shift     <= {in_tdata[23:0], 8'h00};
            r_tvalid    <= 1'b1;
            r_in_tready <= 1'b0;
            r_idx       <= '0;
            r_len_err   <= in_tlast ^ w_last_word;
            r_state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_xfer) begin
            r_csum <= w_csum_nxt;
            r_idx  <= r_idx + 2'd1;
            if (r_idx != 2'd3) begin
              r_tdata <= r_shift[31:24];
              r_shift <= {r_shift[23:0], 8'h00};
            end else begin
              r_rem <= r_rem - CNT_W'(1);
              if (w_last_word) begin
                r_tdata <= w_csum_nxt;
                r_tlast <= 1'b1;
                r_state <= ST_CSUM;
              end else begin
                r_tvalid    <= 1'b0;
                r_in_tready <= 1'b1;
                r_state     <= ST_WAIT_WORD;
              end
            end
          end
        end

        ST_CSUM: begin
          if (w_xfer) begin
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_tvalid      <= 1'b0;
          r_tlast       <= 1'b0;
          r_in_tready   <= 1'b0;
          r_start_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready    = r_start_ready;
  assign in_tready      = r_in_tready;
  assign tx_fifo_tdata  = r_tdata;
  assign tx_fifo_tvalid = r_tvalid;
  assign tx_fifo_tlast  = r_tlast;
  assign busy           = r_busy;
  assign len_err        = r_len_err;

endmodule

// File: tb/tb_ob_dump_tx_framer.sv
module tb_ob_dump_tx_framer;

  logic        clk_udp = 1'b0;
  logic        rst_udp;
  logic        start_valid;
  logic [7:0]  start_count;
  logic        start_ready;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic [7:0]  tx_fifo_tdata;
  logic        tx_fifo_tvalid;
  logic        tx_fifo_tlast;
  logic        tx_fifo_tready;
  logic        busy;
  logic        len_err;

  ob_dump_tx_framer #(
    .OPCODE(24'hF0E0D0),
    .CNT_W (8)
  ) dut (
    .clk_udp       (clk_udp),
    .rst_udp       (rst_udp),
    .start_valid   (start_valid),
    .start_count   (start_count),
    .start_ready   (start_ready),
    .in_tdata      (in_tdata),
    .in_tvalid     (in_tvalid),
    .in_tlast      (in_tlast),
    .in_tready     (in_tready),
    .tx_fifo_tdata (tx_fifo_tdata),
    .tx_fifo_tvalid(tx_fifo_tvalid),
    .tx_fifo_tlast (tx_fifo_tlast),
    .tx_fifo_tready(tx_fifo_tready),
    .busy          (busy),
    .len_err       (len_err)
  );

  always #5 clk_udp = ~clk_udp;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus words/tlast for the current scenario, and the live feed queues.
  logic [31:0] stim_w[$];
  logic        stim_l[$];
  logic [31:0] feed_w[$];
  logic        feed_l[$];
  logic [7:0]  exp_b[$];
  logic [7:0]  cap_b[$];
  logic        cap_t[$];
  int          frames_done = 0;
  int          len_err_cnt = 0;
  bit          acc_flag = 1'b0;
  int          tmode = 0;
  int          gap_pct = 0;
  int          pat_cnt = 0;

  // Reference model: frame = opcode(3) + count + words MSB-first + XOR of all.
  function automatic void model_frame(input int n);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    logic [23:0] op;
    op = 24'hF0E0D0;
    x = 8'h00;
    for (int k = 2; k >= 0; k--) begin
      b = op[8*k +: 8];
      exp_b.push_back(b);
      x = x ^ b;
    end
    b = n[7:0];
    exp_b.push_back(b);
    x = x ^ b;
    for (int i = 0; i < n; i++) begin
      w = stim_w[i];
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        exp_b.push_back(b);
        x = x ^ b;
      end
    end
    exp_b.push_back(x);
  endfunction

  function automatic int model_len_err(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++)
      if (stim_l[i] != (i == n - 1)) c++;
    return c;
  endfunction

  // Input driver: word stream and downstream ready, changed 1 time unit after posedge.
  initial begin
    in_tvalid      = 1'b0;
    in_tdata       = '0;
    in_tlast       = 1'b0;
    tx_fifo_tready = 1'b1;
    forever begin
      @(posedge clk_udp);
      #1;
      if (acc_flag) begin
        acc_flag = 1'b0;
        if (feed_w.size() > 0) begin
          void'(feed_w.pop_front());
          void'(feed_l.pop_front());
        end
        in_tvalid = 1'b0;
      end
      if (feed_w.size() == 0) begin
        in_tvalid = 1'b0;
      end else if (!in_tvalid && ($urandom_range(0, 99) >= gap_pct)) begin
        in_tvalid = 1'b1;
        in_tdata  = feed_w[0];
        in_tlast  = feed_l[0];
      end
      case (tmode)
        0:       tx_fifo_tready = 1'b1;
        1:       tx_fifo_tready = 1'($urandom_range(0, 1));
        default: begin
          tx_fifo_tready = (pat_cnt == 0);
          pat_cnt = (pat_cnt + 1) % 3;
        end
      endcase
    end
  end

  // Monitor at negedge: capture transfers, count len_err pulses, check stall stability.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  initial begin
    forever begin
      @(negedge clk_udp);
      if (rst_udp !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (len_err === 1'b1) len_err_cnt++;
        if (in_tvalid && in_tready === 1'b1) acc_flag = 1'b1;
        if (prev_stall) begin
          n_vec++;
          if (tx_fifo_tvalid !== 1'b1 || tx_fifo_tdata !== prev_data || tx_fifo_tlast !== prev_last) begin
            n_err++;
            $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, need v=1 d=%02h l=%0b",
                     tx_fifo_tvalid, tx_fifo_tdata, tx_fifo_tlast, prev_data, prev_last);
          end
        end
        if (tx_fifo_tvalid === 1'b1 && tx_fifo_tready) begin
          cap_b.push_back(tx_fifo_tdata);
          cap_t.push_back(tx_fifo_tlast);
          if (tx_fifo_tlast === 1'b1) frames_done++;
        end
        prev_stall = (tx_fifo_tvalid === 1'b1) && !tx_fifo_tready;
        prev_data  = tx_fifo_tdata;
        prev_last  = tx_fifo_tlast;
      end
    end
  end

  task automatic sample();
    @(negedge clk_udp);
    #2;
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (start_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_start_ready: got 0 for 20 cycles, need 1", name);
    end
  endtask

  // Runs one frame from stim_w/stim_l and checks bytes, tlast, len_err and return to IDLE.
  task automatic run_frame(input string name, input int n, input int mode, input int gap);
    bit ok;
    int budget;
    int exp_le;
    exp_b.delete();
    model_frame(n);
    exp_le = model_len_err(n);
    cap_b.delete();
    cap_t.delete();
    frames_done = 0;
    len_err_cnt = 0;
    tmode   = mode;
    gap_pct = gap;
    foreach (stim_w[i]) begin
      feed_w.push_back(stim_w[i]);
      feed_l.push_back(stim_l[i]);
    end
    @(posedge clk_udp);
    #1;
    start_valid = 1'b1;
    start_count = n[7:0];
    wait_accept(name);
    @(posedge clk_udp);
    #1;
    start_valid = 1'b0;
    budget = 40 * n + 100;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      if (frames_done > 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_timeout: got no tlast in %0d cycles, need one", name, budget);
    end
    sample();
    n_vec++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || tx_fifo_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_after: got busy=%0b rdy=%0b v=%0b, need 0 1 0",
               name, busy, start_ready, tx_fifo_tvalid);
    end
    n_vec++;
    if (cap_b.size() !== exp_b.size()) begin
      n_err++;
      $display("FAIL %s_len: got %0d bytes, need %0d", name, cap_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
      n_vec++;
      if (cap_b[i] !== exp_b[i] || cap_t[i] !== (i == exp_b.size() - 1)) begin
        n_err++;
        $display("FAIL %s_byte%0d: got %02h tlast=%0b, need %02h tlast=%0b",
                 name, i, cap_b[i], cap_t[i], exp_b[i], (i == exp_b.size() - 1));
      end
    end
    n_vec++;
    if (len_err_cnt !== exp_le) begin
      n_err++;
      $display("FAIL %s_len_err: got %0d pulses, need %0d", name, len_err_cnt, exp_le);
    end
  endtask

  task automatic load_case2();
    stim_w.delete();
    stim_l.delete();
    stim_w.push_back(32'h0064001E); stim_l.push_back(1'b0);
    stim_w.push_back(32'h0069000A); stim_l.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst_udp     = 1'b1;
    start_valid = 1'b1;
    start_count = 8'd3;
    repeat (2) @(posedge clk_udp);
    sample();
    n_vec++;
    if (tx_fifo_tvalid !== 1'b0 || tx_fifo_tlast !== 1'b0 || tx_fifo_tdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_tx: got v=%0b l=%0b d=%02h, need 0 0 00", tx_fifo_tvalid, tx_fifo_tlast, tx_fifo_tdata);
    end
    n_vec++;
    if (in_tready !== 1'b0 || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got in_tready=%0b start_ready=%0b, need 0 1", in_tready, start_ready);
    end
    n_vec++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: got busy=%0b len_err=%0b, need 0 0", busy, len_err);
    end
    start_valid = 1'b0;
    @(posedge clk_udp);
    #1;
    rst_udp = 1'b0;
    sample();
  endtask

  task automatic test_count_zero();
    stim_w.delete();
    stim_l.delete();
    run_frame("cnt0", 0, 0, 0);
    n_vec++;
    if (cap_b.size() != 5 || cap_b[4] !== 8'hC0) begin
      n_err++;
      $display("FAIL cnt0_csum: got size %0d, need 5 bytes ending C0", cap_b.size());
    end
  endtask

  task automatic test_two_words();
    load_case2();
    run_frame("two", 2, 0, 0);
    n_vec++;
    if (cap_b.size() != 13 || cap_b[12] !== 8'hDB) begin
      n_err++;
      $display("FAIL two_csum: got size %0d, need 13 bytes ending DB", cap_b.size());
    end
  endtask

  task automatic test_stall();
    load_case2();
    pat_cnt = 0;
    run_frame("stall", 2, 2, 0);
  endtask

  task automatic test_bad_tlast();
    stim_w.delete();
    stim_l.delete();
    stim_w.push_back($urandom); stim_l.push_back(1'b1);
    stim_w.push_back($urandom); stim_l.push_back(1'b1);
    run_frame("badlast", 2, 0, 30);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    load_case2();
    cap_b.delete();
    cap_t.delete();
    frames_done = 0;
    tmode   = 0;
    gap_pct = 0;
    foreach (stim_w[i]) begin
      feed_w.push_back(stim_w[i]);
      feed_l.push_back(stim_l[i]);
    end
    @(posedge clk_udp);
    #1;
    start_valid = 1'b1;
    start_count = 8'd2;
    wait_accept("midrst");
    @(posedge clk_udp);
    #1;
    start_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (cap_b.size() >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL midrst_progress: got %0d bytes, need 6", cap_b.size());
    end
    @(posedge clk_udp);
    #1;
    rst_udp = 1'b1;
    @(posedge clk_udp);
    #1;
    rst_udp = 1'b0;
    sample();
    n_vec++;
    if (tx_fifo_tvalid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_state: got v=%0b busy=%0b rdy=%0b, need 0 0 1", tx_fifo_tvalid, busy, start_ready);
    end
    n_vec++;
    if (frames_done !== 0) begin
      n_err++;
      $display("FAIL midrst_tlast: got %0d tlast bytes, need 0", frames_done);
    end
    feed_w.delete();
    feed_l.delete();
    acc_flag = 1'b0;
    repeat (3) sample();
    stim_w.delete();
    stim_l.delete();
    stim_w.push_back($urandom); stim_l.push_back(1'b1);
    run_frame("midrst_new", 1, 0, 0);
    n_vec++;
    if (cap_b.size() < 3 || cap_b[0] !== 8'hF0 || cap_b[1] !== 8'hE0 || cap_b[2] !== 8'hD0) begin
      n_err++;
      $display("FAIL midrst_hdr: got %0d bytes, need fresh F0 E0 D0 header", cap_b.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_case2();
    exp_b.delete();
    model_frame(2);
    model_frame(2);
    cap_b.delete();
    cap_t.delete();
    frames_done = 0;
    len_err_cnt = 0;
    tmode   = 0;
    gap_pct = 0;
    for (int r = 0; r < 2; r++)
      foreach (stim_w[i]) begin
        feed_w.push_back(stim_w[i]);
        feed_l.push_back(stim_l[i]);
      end
    @(posedge clk_udp);
    #1;
    start_valid = 1'b1;
    start_count = 8'd2;
    wait_accept("b2b");
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (frames_done > 0) begin
        ok = 1'b1;
        break;
      end
      n_vec++;
      if (start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_held_ready: got 1 at cycle %0d, need 0", i);
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_timeout: got no tlast, need one");
    end
    sample();
    n_vec++;
    if (start_ready !== 1'b1 || tx_fifo_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: got rdy=%0b v=%0b, need 1 0", start_ready, tx_fifo_tvalid);
    end
    sample();
    n_vec++;
    if (tx_fifo_tvalid !== 1'b1 || tx_fifo_tdata !== 8'hF0 || start_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: got v=%0b d=%02h rdy=%0b, need 1 F0 0", tx_fifo_tvalid, tx_fifo_tdata, start_ready);
    end
    @(posedge clk_udp);
    #1;
    start_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (frames_done > 1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_timeout2: got %0d frames, need 2", frames_done);
    end
    n_vec++;
    if (cap_b.size() !== exp_b.size()) begin
      n_err++;
      $display("FAIL b2b_len: got %0d bytes, need %0d", cap_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
      n_vec++;
      if (cap_b[i] !== exp_b[i] || cap_t[i] !== (i == 12 || i == 25)) begin
        n_err++;
        $display("FAIL b2b_byte%0d: got %02h tlast=%0b, need %02h tlast=%0b",
                 i, cap_b[i], cap_t[i], exp_b[i], (i == 12 || i == 25));
      end
    end
    n_vec++;
    if (len_err_cnt !== 0) begin
      n_err++;
      $display("FAIL b2b_len_err: got %0d pulses, need 0", len_err_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    bit bad;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(0, 8);
      bad = ($urandom_range(0, 3) == 0);
      stim_w.delete();
      stim_l.delete();
      for (int i = 0; i < n; i++) begin
        stim_w.push_back($urandom);
        stim_l.push_back(bad ? 1'($urandom_range(0, 1)) : (i == n - 1));
      end
      run_frame("rand", n, $urandom_range(0, 2), $urandom_range(0, 60));
    end
  endtask

  task automatic test_max_count();
    stim_w.delete();
    stim_l.delete();
    for (int i = 0; i < 255; i++) begin
      stim_w.push_back($urandom);
      stim_l.push_back(i == 254);
    end
    run_frame("max255", 255, 0, 0);
  endtask

  initial begin
    start_valid = 1'b0;
    start_count = '0;
    rst_udp     = 1'b1;
    test_reset();
    test_count_zero();
    test_two_words();
    test_stall();
    test_bad_tlast();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
